// File: rtl/seq_count_up_prog.sv
// Programmable NBITS-wide up counter with start/stop run control, synchronous load,
// and wrap or one-shot end-of-count behaviour.
//
// state | meaning
// IDLE  | holding out, waiting for start or load
// COUNT | incrementing toward limit each cycle
// DONE  | one-shot finished, out parked at limit
module seq_count_up_prog #(
  parameter int NBITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic [NBITS-1:0] limit,
  input  logic             mode,
  output logic [NBITS-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= '0;
      state <= IDLE;
    end else if (load) begin
      out <= load_val;
      if (state == DONE) state <= IDLE;
    end else if (stop) begin
      if (state == COUNT) state <= IDLE;
    end else if (start && (state != COUNT)) begin
      // Leaving DONE restarts from zero; leaving IDLE resumes from the held value.
      if (state == DONE) out <= '0;
      state <= COUNT;
    end else if (state == COUNT) begin
      if (out != limit) begin
        out <= out + 1'b1;
      end else if (!mode) begin
        out <= '0;
      end else begin
        state <= DONE;
      end
    end
  end

  assign busy = (state == COUNT);
  assign done = (state == DONE);
  assign tc   = (state == COUNT) && (out == limit);

endmodule

// File: tb/tb_seq_count_up_prog.sv
// Directed bench for seq_count_up_prog: the stimulus pushes hand-computed expectations,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_seq_count_up_prog;

  localparam int NBITS = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             load = 1'b0;
  logic [NBITS-1:0] load_val = '0;
  logic [NBITS-1:0] limit = '0;
  logic             mode = 1'b0;
  logic [NBITS-1:0] out;
  logic             busy;
  logic             tc;
  logic             done;

  typedef struct {
    int         id;
    logic [2:0] e_out;
    logic       e_busy;
    logic       e_tc;
    logic       e_done;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int step_id = 0;

  seq_count_up_prog #(.NBITS(NBITS)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .load(load),
    .load_val(load_val),
    .limit(limit),
    .mode(mode),
    .out(out),
    .busy(busy),
    .tc(tc),
    .done(done)
  );

  always #5 clk = ~clk;

  // Inputs change just after a negedge and stay put through the next posedge and
  // the negedge that follows, so the combinational tc is checked with the same limit.
  task automatic step(input int rst, input int st, input int sp, input int ld,
                      input int lv, input int lim, input int md,
                      input int eo, input int eb, input int et, input int ed);
    exp_t e;
    @(negedge clk);
    #1;
    reset    = rst[0];
    start    = st[0];
    stop     = sp[0];
    load     = ld[0];
    load_val = lv[2:0];
    limit    = lim[2:0];
    mode     = md[0];
    step_id++;
    e.id     = step_id;
    e.e_out  = eo[2:0];
    e.e_busy = eb[0];
    e.e_tc   = et[0];
    e.e_done = ed[0];
    sbq.push_back(e);
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      if (out !== e.e_out || busy !== e.e_busy || tc !== e.e_tc || done !== e.e_done) begin
        bad++;
        $display("FAIL step %0d: got out=%0d busy=%b tc=%b done=%b, required out=%0d busy=%b tc=%b done=%b",
                 e.id, out, busy, tc, done, e.e_out, e.e_busy, e.e_tc, e.e_done);
      end
    end
  end

  initial begin
    //     rst st sp ld lv lim md   out busy tc done
    // 1. reset then idle
    step(1, 0, 0, 0, 0, 5, 0,   0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 5, 0,   0, 0, 0, 0);

    // 2. wrap, limit=5; a start while counting is ignored
    step(0, 1, 0, 0, 0, 5, 0,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 5, 0,   2, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   4, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   5, 1, 1, 0);
    step(0, 0, 0, 0, 0, 5, 0,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   1, 1, 0, 0);

    // 3. one-shot, limit=3, then restart from DONE
    step(1, 0, 0, 0, 0, 3, 1,   0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 3, 1,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3, 1,   1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3, 1,   2, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3, 1,   3, 1, 1, 0);
    step(0, 0, 0, 0, 0, 3, 1,   3, 0, 0, 1);
    step(0, 0, 0, 0, 0, 3, 1,   3, 0, 0, 1);
    step(0, 1, 0, 0, 0, 3, 1,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 3, 1,   1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 3, 1,   1, 0, 0, 0);

    // 4. full-range wrap at limit=7
    step(1, 0, 0, 0, 0, 7, 0,   0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 7, 0,   0, 1, 0, 0);
    for (int i = 1; i < 7; i++) step(0, 0, 0, 0, 0, 7, 0,   i, 1, 0, 0);
    step(0, 0, 0, 0, 0, 7, 0,   7, 1, 1, 0);
    step(0, 0, 0, 0, 0, 7, 0,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 7, 0,   1, 1, 0, 0);

    // 4b. limit=0 wrap stays at 0 with tc high; switching mode mid-count ends in DONE
    step(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1);

    // 5a. load above limit while counting climbs through the wrap back to limit
    step(0, 1, 0, 0, 0, 2, 0,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 2, 0,   1, 1, 0, 0);
    step(0, 0, 0, 1, 6, 2, 0,   6, 1, 0, 0);
    step(0, 0, 0, 0, 0, 2, 0,   7, 1, 0, 0);
    step(0, 0, 0, 0, 0, 2, 0,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 2, 0,   1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 2, 0,   2, 1, 1, 0);
    step(0, 0, 0, 0, 0, 2, 0,   0, 1, 0, 0);

    // 5b. stop at 4, resume, start+stop, load+stop in IDLE and in COUNT
    step(0, 0, 0, 0, 0, 5, 0,   1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   2, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   4, 1, 0, 0);
    step(0, 0, 1, 0, 0, 5, 0,   4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   4, 0, 0, 0);
    step(0, 1, 0, 0, 0, 5, 0,   4, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   5, 1, 1, 0);
    step(0, 0, 1, 0, 0, 5, 0,   5, 0, 0, 0);
    step(0, 1, 1, 0, 0, 5, 0,   5, 0, 0, 0);
    step(0, 0, 1, 1, 2, 5, 0,   2, 0, 0, 0);
    step(0, 1, 0, 0, 0, 5, 0,   2, 1, 0, 0);
    step(0, 0, 1, 1, 3, 5, 0,   3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 5, 0,   4, 1, 0, 0);

    // 6. reset mid-count at out=4, then reset in DONE, then load out of DONE
    step(1, 0, 0, 0, 0, 5, 0,   0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1,   1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 1);
    step(1, 1, 0, 1, 6, 1, 1,   0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1,   0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1,   1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 1);
    step(0, 0, 0, 1, 5, 1, 1,   5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1,   5, 0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
      #1;
    end
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
